// File: rtl/tensor_split_pkg.sv
// Shared types and elaboration helpers for the tensor_split_2 stream splitter.
package tensor_split_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;

  // A frame must hold a whole number of Output_1/Output_2 group pairs.
  function automatic bit frame_cfg_ok(input int frame_words, input int group_words);
    return (group_words >= 1) && (frame_words > 0) &&
           ((frame_words % (2 * group_words)) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO; head is the oldest entry, pushes while full are dropped.
module stream_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full is taken from the registered count, so a same-cycle pop never admits a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
    end
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tensor_split_2.sv
// Deals one ap_hs input stream in GROUP_WORDS-sized groups onto two ap_hs outputs.
// state | meaning: IDLE waits for ap_start | RUN accepts words | DRAIN empties both FIFOs
module tensor_split_2
  import tensor_split_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int GROUP_WORDS = 2,
  parameter int FRAME_WORDS = 1024
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [DATA_WIDTH-1:0] Input_1_V_V,
  input  logic                  Input_1_V_V_ap_vld,
  output logic                  Input_1_V_V_ap_ack,
  output logic [DATA_WIDTH-1:0] Output_1_V_V,
  output logic                  Output_1_V_V_ap_vld,
  input  logic                  Output_1_V_V_ap_ack,
  output logic [DATA_WIDTH-1:0] Output_2_V_V,
  output logic                  Output_2_V_V_ap_vld,
  input  logic                  Output_2_V_V_ap_ack
);

  localparam int GW = (GROUP_WORDS > 1) ? $clog2(GROUP_WORDS) : 1;
  localparam int FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  if (!frame_cfg_ok(FRAME_WORDS, GROUP_WORDS)) begin : g_cfg_err
    $error("tensor_split_2: FRAME_WORDS must be a non-zero multiple of 2*GROUP_WORDS");
  end

  state_e          state_q, state_d;
  logic [GW-1:0]   grp_cnt_q, grp_cnt_d;
  logic [FW-1:0]   frm_cnt_q, frm_cnt_d;
  logic            sel_q, sel_d;

  logic            full1, empty1, full2, empty2;
  logic [1:0]      cnt1, cnt2;
  logic            push1, push2, pop1, pop2;
  logic            sel_full, in_xfer, last_in;
  logic            last1, last2, drain_fin;

  assign sel_full = sel_q ? full2 : full1;
  assign in_xfer  = (state_q == RUN) && !sel_full && Input_1_V_V_ap_vld;
  assign last_in  = (frm_cnt_q == FW'(FRAME_WORDS - 1));

  assign push1 = in_xfer && !sel_q;
  assign push2 = in_xfer && sel_q;
  assign pop1  = !empty1 && Output_1_V_V_ap_ack;
  assign pop2  = !empty2 && Output_2_V_V_ap_ack;

  // Drain finishes on the transfer that leaves both FIFOs empty.
  assign last1     = empty1 || (pop1 && (cnt1 == 2'd1));
  assign last2     = empty2 || (pop2 && (cnt2 == 2'd1));
  assign drain_fin = (state_q == DRAIN) && last1 && last2 && (pop1 || pop2);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (in_xfer && last_in) state_d = DRAIN;
      DRAIN:   if (drain_fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ap_idle            = 1'b0;
    Input_1_V_V_ap_ack = 1'b0;
    ap_ready           = 1'b0;
    ap_done            = 1'b0;
    unique case (state_q)
      IDLE:  ap_idle = 1'b1;
      RUN: begin
        Input_1_V_V_ap_ack = !sel_full;
        ap_ready           = in_xfer && last_in;
      end
      DRAIN: ap_done = drain_fin;
      default: ;
    endcase
  end

  always_comb begin
    grp_cnt_d = grp_cnt_q;
    frm_cnt_d = frm_cnt_q;
    sel_d     = sel_q;
    if ((state_q == IDLE) && ap_start) begin
      grp_cnt_d = '0;
      frm_cnt_d = '0;
      sel_d     = 1'b0;
    end else if (in_xfer) begin
      frm_cnt_d = frm_cnt_q + FW'(1);
      if (grp_cnt_q == GW'(GROUP_WORDS - 1)) begin
        grp_cnt_d = '0;
        sel_d     = !sel_q;
      end else begin
        grp_cnt_d = grp_cnt_q + GW'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      grp_cnt_q <= '0;
      frm_cnt_q <= '0;
      sel_q     <= 1'b0;
    end else begin
      grp_cnt_q <= grp_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      sel_q     <= sel_d;
    end
  end

  stream_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo1 (
    .clk_i   (ap_clk),
    .rst_i   (ap_rst),
    .push_i  (push1),
    .data_i  (Input_1_V_V),
    .pop_i   (pop1),
    .full_o  (full1),
    .empty_o (empty1),
    .count_o (cnt1),
    .head_o  (Output_1_V_V)
  );

  stream_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo2 (
    .clk_i   (ap_clk),
    .rst_i   (ap_rst),
    .push_i  (push2),
    .data_i  (Input_1_V_V),
    .pop_i   (pop2),
    .full_o  (full2),
    .empty_o (empty2),
    .count_o (cnt2),
    .head_o  (Output_2_V_V)
  );

  assign Output_1_V_V_ap_vld = !empty1;
  assign Output_2_V_V_ap_vld = !empty2;

endmodule

// File: tb/tb_tensor_split_2.sv
// Scoreboard bench for tensor_split_2 with GROUP_WORDS=2, FRAME_WORDS=8.
module tb_tensor_split_2;

  localparam int DW = 32;
  localparam int GW = 2;
  localparam int FW = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_done, ap_idle, ap_ready;
  logic [DW-1:0] Input_1_V_V;
  logic          Input_1_V_V_ap_vld;
  logic          Input_1_V_V_ap_ack;
  logic [DW-1:0] Output_1_V_V;
  logic          Output_1_V_V_ap_vld;
  logic          Output_1_V_V_ap_ack;
  logic [DW-1:0] Output_2_V_V;
  logic          Output_2_V_V_ap_vld;
  logic          Output_2_V_V_ap_ack;

  tensor_split_2 #(
    .DATA_WIDTH  (DW),
    .GROUP_WORDS (GW),
    .FRAME_WORDS (FW)
  ) dut (
    .ap_clk              (ap_clk),
    .ap_rst              (ap_rst),
    .ap_start            (ap_start),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .Input_1_V_V         (Input_1_V_V),
    .Input_1_V_V_ap_vld  (Input_1_V_V_ap_vld),
    .Input_1_V_V_ap_ack  (Input_1_V_V_ap_ack),
    .Output_1_V_V        (Output_1_V_V),
    .Output_1_V_V_ap_vld (Output_1_V_V_ap_vld),
    .Output_1_V_V_ap_ack (Output_1_V_V_ap_ack),
    .Output_2_V_V        (Output_2_V_V),
    .Output_2_V_V_ap_vld (Output_2_V_V_ap_vld),
    .Output_2_V_V_ap_ack (Output_2_V_V_ap_ack)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] exp1[$], exp2[$], got1[$], got2[$];
  int k_idx = 0, acc_cnt = 0, rdy_cnt = 0, done_cnt = 0;
  int ack_run = 0, max_ack_run = 0, idle_run = 0, last_gap = 0;
  int cyc = 0, first_acc = -1, first_vld1 = -1;
  logic rand_en = 1'b0;

  // Reference model: routes each accepted word by its in-frame index.
  always @(negedge ap_clk) begin
    logic x1, x2;
    cyc++;
    if (ap_rst) begin
      exp1.delete();
      exp2.delete();
      k_idx   = 0;
      ack_run = 0;
    end else begin
      if (ap_ready) begin
        rdy_cnt++;
        check_val("ready_on_last", (Input_1_V_V_ap_vld && Input_1_V_V_ap_ack) && (k_idx == FW - 1), 1);
      end
      if (Input_1_V_V_ap_vld && Input_1_V_V_ap_ack) begin
        if (((k_idx / GW) % 2) == 0) exp1.push_back(Input_1_V_V);
        else                         exp2.push_back(Input_1_V_V);
        k_idx = (k_idx + 1) % FW;
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (Output_1_V_V_ap_vld && first_vld1 < 0) first_vld1 = cyc;
      x1 = Output_1_V_V_ap_vld && Output_1_V_V_ap_ack;
      x2 = Output_2_V_V_ap_vld && Output_2_V_V_ap_ack;
      if (x1) begin
        got1.push_back(Output_1_V_V);
        check_val("o1_queued", exp1.size() != 0, 1);
        if (exp1.size() != 0) check_val("o1_data", Output_1_V_V, exp1.pop_front());
      end
      if (x2) begin
        got2.push_back(Output_2_V_V);
        check_val("o2_queued", exp2.size() != 0, 1);
        if (exp2.size() != 0) check_val("o2_data", Output_2_V_V, exp2.pop_front());
      end
      if (ap_done) begin
        done_cnt++;
        check_val("done_on_last", (x1 || x2) && exp1.size() == 0 && exp2.size() == 0, 1);
      end
      if (Input_1_V_V_ap_ack) ack_run++;
      else ack_run = 0;
      if (ack_run > max_ack_run) max_ack_run = ack_run;
      if (ap_idle) idle_run++;
      else begin
        if (idle_run != 0) last_gap = idle_run;
        idle_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input int max_bubble);
    int n;
    n = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
    if (n > 0) begin
      Input_1_V_V_ap_vld = 1'b0;
      repeat (n) tick();
    end
    Input_1_V_V        = d;
    Input_1_V_V_ap_vld = 1'b1;
    for (int t = 0; t <= 200; t++) begin
      @(negedge ap_clk);
      if (Input_1_V_V_ap_ack) begin
        tick();
        break;
      end
      if (t == 200) check_val("send_timeout", Input_1_V_V_ap_ack, 1);
    end
  endtask

  task automatic send_frame(input logic [31:0] base, input int nwords, input int max_bubble);
    for (int i = 0; i < nwords; i++) send_word(base + 32'(i), max_bubble);
    Input_1_V_V_ap_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t <= 300; t++) begin
      @(negedge ap_clk);
      if (ap_idle && exp1.size() == 0 && exp2.size() == 0) break;
      if (t == 300) check_val(tag, ap_idle, 1);
    end
    tick();
  endtask

  task automatic clear_stats();
    got1.delete();
    got2.delete();
    acc_cnt     = 0;
    rdy_cnt     = 0;
    done_cnt    = 0;
    max_ack_run = 0;
    first_acc   = -1;
    first_vld1  = -1;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check_val({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check_val(tag, (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp[i]);
  endtask

  task automatic start_frame(input logic [31:0] first);
    Input_1_V_V        = first;
    Input_1_V_V_ap_vld = 1'b1;
    ap_start           = 1'b1;
    tick();
    ap_start = 1'b0;
    check_val("idle_fall", ap_idle, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=%0d exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] want[$];
    ap_rst = 1'b1;
    ap_start = 1'b0;
    Input_1_V_V = '0;
    Input_1_V_V_ap_vld = 1'b0;
    Output_1_V_V_ap_ack = 1'b0;
    Output_2_V_V_ap_ack = 1'b0;
    repeat (3) tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_val("rst_idle", ap_idle, 1);
    check_val("rst_in_ack", Input_1_V_V_ap_ack, 0);
    check_val("rst_o1_vld", Output_1_V_V_ap_vld, 0);
    check_val("rst_o2_vld", Output_2_V_V_ap_vld, 0);
    check_val("rst_done", ap_done, 0);
    check_val("rst_ready", ap_ready, 0);
    check_val("rst_o1_data", Output_1_V_V, 0);
    check_val("rst_o2_data", Output_2_V_V, 0);
    tick();

    // Basic routing and full throughput
    clear_stats();
    Output_1_V_V_ap_ack = 1'b1;
    Output_2_V_V_ap_ack = 1'b1;
    start_frame(32'h10);
    send_frame(32'h10, FW, 0);
    wait_idle("s1_idle");
    want = {32'h10, 32'h11, 32'h14, 32'h15};
    check_seq("s1_o1", got1, want);
    want = {32'h12, 32'h13, 32'h16, 32'h17};
    check_seq("s1_o2", got2, want);
    check_val("s1_ready_cnt", rdy_cnt, 1);
    check_val("s1_done_cnt", done_cnt, 1);
    check_val("s1_idle_back", ap_idle, 1);
    check_val("s2_ack_run", max_ack_run, FW);
    check_val("s2_latency", first_vld1 - first_acc, 1);

    // Backpressure on Output_2
    clear_stats();
    Output_2_V_V_ap_ack = 1'b0;
    start_frame(32'h10);
    fork
      send_frame(32'h10, FW, 0);
    join_none
    repeat (12) @(negedge ap_clk);
    check_val("s3_acc_stall", acc_cnt, 6);
    check_val("s3_in_ack", Input_1_V_V_ap_ack, 0);
    check_val("s3_o1_flow", got1.size(), 4);
    check_val("s3_o2_vld", Output_2_V_V_ap_vld, 1);
    check_val("s3_o2_head", Output_2_V_V, 32'h12);
    tick();
    Output_2_V_V_ap_ack = 1'b1;
    wait fork;
    wait_idle("s3_idle");
    want = {32'h10, 32'h11, 32'h14, 32'h15};
    check_seq("s3_o1", got1, want);
    want = {32'h12, 32'h13, 32'h16, 32'h17};
    check_seq("s3_o2", got2, want);
    check_val("s3_done_cnt", done_cnt, 1);

    // Back-to-back frames with ap_start held
    clear_stats();
    Input_1_V_V        = 32'h20;
    Input_1_V_V_ap_vld = 1'b1;
    ap_start           = 1'b1;
    send_frame(32'h20, 2 * FW, 0);
    ap_start = 1'b0;
    wait_idle("s4_idle");
    check_val("s4_gap", last_gap, 1);
    check_val("s4_ready_cnt", rdy_cnt, 2);
    check_val("s4_done_cnt", done_cnt, 2);
    want = {32'h20, 32'h21, 32'h24, 32'h25, 32'h28, 32'h29, 32'h2C, 32'h2D};
    check_seq("s4_o1", got1, want);
    want = {32'h22, 32'h23, 32'h26, 32'h27, 32'h2A, 32'h2B, 32'h2E, 32'h2F};
    check_seq("s4_o2", got2, want);

    // Mid-frame reset after 5 accepted words
    clear_stats();
    Output_2_V_V_ap_ack = 1'b0;
    start_frame(32'h40);
    for (int i = 0; i < 5; i++) send_word(32'h40 + 32'(i), 0);
    Input_1_V_V_ap_vld = 1'b0;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_val("s5_o1_vld", Output_1_V_V_ap_vld, 0);
    check_val("s5_o2_vld", Output_2_V_V_ap_vld, 0);
    check_val("s5_idle", ap_idle, 1);
    check_val("s5_in_ack", Input_1_V_V_ap_ack, 0);
    tick();
    clear_stats();
    Output_2_V_V_ap_ack = 1'b1;
    start_frame(32'h50);
    send_frame(32'h50, FW, 0);
    wait_idle("s5_idle_after");
    want = {32'h50, 32'h51, 32'h54, 32'h55};
    check_seq("s5_o1", got1, want);
    want = {32'h52, 32'h53, 32'h56, 32'h57};
    check_seq("s5_o2", got2, want);

    // Soak: random input bubbles and random consumer acks
    clear_stats();
    rand_en = 1'b1;
    fork
      forever begin
        tick();
        if (!rand_en) break;
        Output_1_V_V_ap_ack = ($urandom_range(0, 3) != 0);
        Output_2_V_V_ap_ack = ($urandom_range(0, 3) != 0);
      end
    join_none
    Input_1_V_V        = 32'h1000;
    Input_1_V_V_ap_vld = 1'b1;
    ap_start           = 1'b1;
    send_frame(32'h1000, 1000 * FW, 2);
    ap_start = 1'b0;
    rand_en  = 1'b0;
    tick();
    Output_1_V_V_ap_ack = 1'b1;
    Output_2_V_V_ap_ack = 1'b1;
    wait_idle("s6_idle");
    check_val("s6_ready_cnt", rdy_cnt, 1000);
    check_val("s6_done_cnt", done_cnt, 1000);
    check_val("s6_o1_cnt", got1.size(), 500 * FW);
    check_val("s6_o2_cnt", got2.size(), 500 * FW);
    check_val("s6_left", exp1.size() + exp2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
